// File: rtl/mux_display_n_digitos.sv
// mux_display_n_digitos: time-multiplexed driver for N common-anode 7-segment digits.
// Latency: all outputs registered, 1 cycle behind cnt/idx/shadow; Carregar visible within 1 frame + 1 cycle.
// No backpressure: free-running scan. Optional macro MUX_DISPLAY_ZERO_BLANK_EN enables leading-zero suppression.
module mux_display_n_digitos #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_valores,
  input  logic [DIGITS-1:0]     i_apagar,
  input  logic                  i_carregar,
  output logic [6:0]            o_output,
  output logic [DIGITS-1:0]     o_digito_aceso,
  output logic                  o_quadro
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {GAPO, ATIVO} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_staging;
  logic [4*DIGITS-1:0]   r_shadow;
  logic                  r_pend;
  logic [6:0]            r_output;
  logic [DIGITS-1:0]     r_anodo;
  logic                  r_quadro;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_zb;
  logic                  w_blank;
  logic [6:0]            w_seg_nxt;
  logic [DIGITS-1:0]     w_an_nxt;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CW'(DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(DIGITS - 1));
  assign w_nib       = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_blank     = i_apagar[r_idx] | w_zb[r_idx];

  // Leading-zero mask from the top digit down; digit 0 always shown
  always_comb begin
    w_zb = '0;
`ifdef MUX_DISPLAY_ZERO_BLANK_EN
    begin : zero_scan
      logic v_lead;
      v_lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        v_lead  = v_lead && (r_shadow[4*i +: 4] == 4'h0);
        w_zb[i] = v_lead;
      end
    end
`endif
  end

  // Prescaler counts a slot; digit index advances on each slot wrap
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= w_frame_end ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Slot phase register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= GAPO;
    else         r_state <= w_state_nxt;
  end

  // Phase transitions and next-cycle anode/segment values
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = 7'h7F;
    w_an_nxt    = '1;
    case (r_state)
      GAPO: begin
        if (r_cnt == CW'(GAP - 1)) w_state_nxt = ATIVO;
      end
      ATIVO: begin
        w_an_nxt[r_idx] = 1'b0;
        if (!w_blank) w_seg_nxt = decode(w_nib);
        if (w_slot_end) w_state_nxt = GAPO;
      end
      default: w_state_nxt = GAPO;
    endcase
  end

  // Double buffer: staging takes loads, shadow swaps only at the frame boundary
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_staging <= '0;
      r_shadow  <= '0;
      r_pend    <= 1'b0;
    end else if (w_frame_end) begin
      r_pend <= 1'b0;
      if (i_carregar) begin
        r_staging <= i_valores;
        r_shadow  <= i_valores;
      end else if (r_pend) begin
        r_shadow  <= r_staging;
      end
    end else if (i_carregar) begin
      r_staging <= i_valores;
      r_pend    <= 1'b1;
    end
  end

  // Registered pin drivers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_output <= 7'h7F;
      r_anodo  <= '1;
      r_quadro <= 1'b0;
    end else begin
      r_output <= w_seg_nxt;
      r_anodo  <= w_an_nxt;
      r_quadro <= w_frame_end;
    end
  end

  assign o_output       = r_output;
  assign o_digito_aceso = r_anodo;
  assign o_quadro       = r_quadro;

endmodule

// File: tb/tb_mux_display_n_digitos.sv
// tb_mux_display_n_digitos: directed bench, DIGITS=4, DIV=4, GAP=1 (16-cycle frame).
// Each frame step lists the shadow value expected on screen plus any loads to apply.
// Honours MUX_DISPLAY_ZERO_BLANK_EN for the expected blanking masks.
module tb_mux_display_n_digitos;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] valores = '0;
  logic [3:0]  apagar = '0;
  logic        carregar = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        quadro;

  int errors = 0;
  int checks = 0;

`ifdef MUX_DISPLAY_ZERO_BLANK_EN
  localparam logic [3:0] ZB_0000 = 4'b1110;
  localparam logic [3:0] ZB_0050 = 4'b1100;
`else
  localparam logic [3:0] ZB_0000 = 4'b0000;
  localparam logic [3:0] ZB_0050 = 4'b0000;
`endif

  mux_display_n_digitos #(.DIGITS(4), .DIV(4), .GAP(1)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valores      (valores),
    .i_apagar       (apagar),
    .i_carregar     (carregar),
    .o_output       (seg),
    .o_digito_aceso (an),
    .o_quadro       (quadro)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Run ncyc cycles of a frame starting at its first cycle, applying up to two loads
  task automatic run_frame(input logic [15:0] shadow, input logic [3:0] apag, input logic [3:0] zb,
                           input int ncyc, input int lj1, input logic [15:0] lv1,
                           input int lj2, input logic [15:0] lv2, input string tag);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s;
    int ph;
    apagar = apag;
    for (int j = 1; j <= ncyc; j++) begin
      if (j == lj1) begin
        carregar = 1'b1;
        valores  = lv1;
      end else if (j == lj2) begin
        carregar = 1'b1;
        valores  = lv2;
      end else begin
        carregar = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      s  = (j - 1) / 4;
      ph = (j - 1) % 4;
      exp_an  = 4'b1111;
      exp_seg = 7'h7F;
      if (ph != 0) begin
        exp_an[s] = 1'b0;
        if (!apag[s] && !zb[s]) exp_seg = glyph(shadow[4*s +: 4]);
      end
      chk4($sformatf("%s_an_c%0d", tag, j), an, exp_an);
      chk7($sformatf("%s_seg_c%0d", tag, j), seg, exp_seg);
      chk1($sformatf("%s_quadro_c%0d", tag, j), quadro, j == 16);
    end
    carregar = 1'b0;
  endtask

  initial begin
    #3 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk7("reset_seg", seg, 7'h7F);
    chk4("reset_an", an, 4'b1111);
    chk1("reset_quadro", quadro, 1'b0);
    rst = 1'b0;

    // Load during first frame; frame 0 still shows zeros
    run_frame(16'h0000, 4'b0000, ZB_0000, 16, 1, 16'h4321, 0, 16'h0, "f0_zero");
    run_frame(16'h4321, 4'b0000, 4'b0000, 16, 0, 16'h0, 0, 16'h0, "f1_scan");
    // Load during digit 1's slot must not tear this frame
    run_frame(16'h4321, 4'b0000, 4'b0000, 16, 6, 16'hABCD, 0, 16'h0, "f2_tear");
    // Load on the exact boundary cycle goes straight to shadow
    run_frame(16'hABCD, 4'b0000, 4'b0000, 16, 16, 16'h8888, 0, 16'h0, "f3_bound");
    // Blank digit 2; two loads, last one wins
    run_frame(16'h8888, 4'b0100, 4'b0000, 16, 2, 16'h1111, 5, 16'h0050, "f4_apagar");
    run_frame(16'h0050, 4'b0000, ZB_0050, 16, 16, 16'h0000, 0, 16'h0, "f5_0050");
    run_frame(16'h0000, 4'b0000, ZB_0000, 16, 3, 16'hFEDC, 0, 16'h0, "f6_0000");
    run_frame(16'hFEDC, 4'b0000, 4'b0000, 16, 0, 16'h0, 0, 16'h0, "f7_hex");
    // Pending load then reset mid-slot 2
    run_frame(16'hFEDC, 4'b0000, 4'b0000, 10, 3, 16'h7777, 0, 16'h0, "f8_pre_rst");
    rst = 1'b1;
    #1;
    chk7("midrst_async_seg", seg, 7'h7F);
    chk4("midrst_async_an", an, 4'b1111);
    chk1("midrst_async_quadro", quadro, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk7("midrst_seg", seg, 7'h7F);
    chk4("midrst_an", an, 4'b1111);
    chk1("midrst_quadro", quadro, 1'b0);
    rst = 1'b0;
    run_frame(16'h0000, 4'b0000, ZB_0000, 16, 0, 16'h0, 0, 16'h0, "f9_after_rst");
    run_frame(16'h0000, 4'b0000, ZB_0000, 16, 0, 16'h0, 0, 16'h0, "f10_discard");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
